// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM state type and counter-width helper for the serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        NEG   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit counter width: enough to count 0 .. width-1.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_fullsub.sv
// rtl/serial_subtractor_fullsub.sv - combinational one-bit full-subtractor cell
module fullsubtractor_module (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out of x - y - bin.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned a-b, LSB first; ABS_DIFF_EN makes diff = |a-b|
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    import serial_sub_pkg::*;

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] diff_q;
    logic             bin_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic cell_x;
    logic cell_y;
    logic cell_d;
    logic cell_bout;

    // Operand mux: the single cell subtracts the operand LSBs, or negates diff during NEG.
    always_comb begin
        cell_x = a_sr_q[0];
        cell_y = b_sr_q[0];
`ifdef ABS_DIFF_EN
        if (state_q == NEG) begin
            cell_x = 1'b0;
            cell_y = diff_q[0];
        end
`endif
    end

    fullsubtractor_module u_cell (
        .x    (cell_x),
        .y    (cell_y),
        .bin  (bin_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Control FSM and serial datapath; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            diff_q      <= '0;
            bin_q       <= 1'b0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_q     <= a;
                        b_sr_q     <= b;
                        bin_q      <= 1'b0;
                        borrow_q   <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end

                SHIFT: begin
                    diff_q <= {cell_d, diff_q[WIDTH-1:1]};
                    a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
                    bin_q  <= cell_bout;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // Final borrow-out is the a<b flag; it survives the NEG pass.
                        borrow_q <= cell_bout;
                        cnt_q    <= '0;
`ifdef ABS_DIFF_EN
                        if (cell_bout) begin
                            bin_q   <= 1'b0;
                            state_q <= NEG;
                        end else begin
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
`else
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`endif
                    end
                end

                NEG: begin
`ifdef ABS_DIFF_EN
                    diff_q <= {cell_d, diff_q[WIDTH-1:1]};
                    bin_q  <= cell_bout;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
`else
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
`endif
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (honours ABS_DIFF_EN)
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;

    typedef struct packed {
        logic [W-1:0] d;
        logic         br;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input int unsigned x, input int unsigned y);
        res_t r;
        r.br = (x < y);
`ifdef ABS_DIFF_EN
        r.d = W'((x < y) ? (y - x) : (x - y));
`else
        r.d = W'((x + (1 << W) - y) % (1 << W));
`endif
        return r;
    endfunction

    function automatic int exp_lat(input int unsigned x, input int unsigned y);
`ifdef ABS_DIFF_EN
        return (x < y) ? 2 * W : W;
`else
        if (x < y) return W;
        return W;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every result handshake pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%0d required=none", diff);
            end else begin
                mon_e = exp_q.pop_front();
                chk("diff", {24'd0, diff}, {24'd0, mon_e.d});
                chk("borrow", {31'd0, borrow}, {31'd0, mon_e.br});
            end
        end
    end

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int bp);
        int           n;
        int           lat;
        logic [W-1:0] d0;
        logic         b0;
        out_ready = (bp == 0);
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
            return;
        end
        a = x;
        b = y;
        in_valid = 1'b1;
        tick();
        exp_q.push_back(model(x, y));
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 4 * W) begin
            tick();
            lat++;
        end
        chk("latency", lat, exp_lat(x, y));
        if (bp > 0) begin
            d0 = diff;
            b0 = borrow;
            in_valid = 1'b1;
            for (int i = 0; i < bp; i++) begin
                tick();
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_diff", {24'd0, diff}, {24'd0, d0});
                chk("bp_borrow", {31'd0, borrow}, {31'd0, b0});
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("in_ready_back", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           accepts;
        int           cyc;
        int           last_cyc;
        int           prev_int;
        int           n;
        logic         r;
        logic [W-1:0] x;
        logic [W-1:0] y;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_borrow", {31'd0, borrow}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed vectors, including zero/all-ones boundaries.
        run_op(8'd200, 8'd55, 0);
        run_op(8'd55, 8'd200, 0);
        run_op(8'd0, 8'd0, 0);
        run_op(8'd255, 8'd0, 0);
        run_op(8'd0, 8'd1, 0);
        run_op(8'd0, 8'd255, 0);
        run_op(8'd200, 8'd55, 5);
        run_op(8'd55, 8'd200, 5);

        // Reset in the middle of SHIFT discards the operation.
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        a = 8'd123;
        b = 8'd45;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3 * W; i++) begin
            tick();
            if (out_valid) chk("midrst_spurious", {31'd0, out_valid}, 32'd0);
        end
        run_op(8'd10, 8'd3, 0);

        // Randomized operations with random backpressure.
        for (int i = 0; i < 24; i++) begin
            x = W'($urandom);
            y = (i % 6 == 0) ? x : W'($urandom);
            run_op(x, y, int'($urandom_range(0, 3)));
        end

        // Back-to-back streaming: in_valid held high, new pair after each accept.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = W'($urandom);
        b         = W'($urandom);
        accepts   = 0;
        cyc       = 0;
        last_cyc  = 0;
        prev_int  = 0;
        while (accepts < 10 && cyc < 2000) begin
            r = in_ready;
            tick();
            cyc++;
            if (r) begin
                exp_q.push_back(model(a, b));
                if (accepts > 0) chk("issue_interval", cyc - last_cyc, prev_int);
                prev_int = exp_lat(a, b) + 2;
                last_cyc = cyc;
                accepts++;
                a = W'($urandom);
                b = W'($urandom);
                if (accepts == 10) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("stream_accepts", accepts, 10);
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
